// File: rtl/time_param_timer_if.sv
// rtl/time_param_timer_if.sv - programming, interval select and countdown signals of the phase timer
interface time_param_timer_if #(
  parameter int SEL_W = 2,
  parameter int VAL_W = 4
);
  logic             prog_req;
  logic [SEL_W-1:0] prog_sel;
  logic [VAL_W-1:0] prog_value;
  logic             prog_ack;
  logic             prog_err;
  logic [SEL_W-1:0] interval_sel;
  logic [VAL_W-1:0] value;
  logic             start;
  logic             abort;
  logic             tick;
  logic [VAL_W-1:0] count;
  logic             busy;
  logic             expired;

  modport master (
    output prog_req, prog_sel, prog_value, interval_sel, start, abort, tick,
    input  prog_ack, prog_err, value, count, busy, expired
  );

  modport slave (
    input  prog_req, prog_sel, prog_value, interval_sel, start, abort, tick,
    output prog_ack, prog_err, value, count, busy, expired
  );
endinterface

// File: rtl/time_param_timer.sv
// rtl/time_param_timer.sv - programmable phase-duration store with tick-driven countdown
// Optional TP_PROG_LOCK_EN: reject programming while a countdown is running.
module time_param_timer #(
  parameter int                            NUM_PARAMS = 3,
  parameter int                            SEL_W      = 2,
  parameter int                            VAL_W      = 4,
  parameter logic [NUM_PARAMS*VAL_W-1:0]   DEFAULTS   = {4'd2, 4'd3, 4'd6}
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  time_param_timer_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [VAL_W-1:0] param_q [NUM_PARAMS];
  logic [VAL_W-1:0] param_d [NUM_PARAMS];
  logic [VAL_W-1:0] value_q, value_d;
  logic [VAL_W-1:0] count_q, count_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             expired_q, expired_d;
  logic             prog_valid;
  logic             lock;

  function automatic logic [VAL_W-1:0] default_of(input int idx);
    return DEFAULTS[idx*VAL_W +: VAL_W];
  endfunction

`ifdef TP_PROG_LOCK_EN
  assign lock = (state_q == RUN);
`else
  assign lock = 1'b0;
`endif

  assign prog_valid = (int'(bus.prog_sel) < NUM_PARAMS);

  // Selected interval from the registers as they stand before this edge's write,
  // so a simultaneous start loads the old value.
  always_comb begin
    value_d = '1;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (bus.interval_sel == SEL_W'(i)) value_d = param_q[i];
    end
  end

  always_comb begin
    param_d = param_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (bus.prog_req) begin
      if (lock) begin
        err_d = 1'b1;
      end else if (prog_valid) begin
        ack_d = 1'b1;
        for (int i = 0; i < NUM_PARAMS; i++) begin
          if (bus.prog_sel == SEL_W'(i)) begin
            param_d[i] = (bus.prog_value == '0) ? default_of(i) : bus.prog_value;
          end
        end
      end else begin
        err_d = 1'b1;
        for (int i = 0; i < NUM_PARAMS; i++) param_d[i] = default_of(i);
      end
    end
  end

  // Priority: abort, then start (reload), then tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = value_d;
    end else if (state_q == RUN && bus.tick) begin
      if (count_q > VAL_W'(1)) begin
        count_d = count_q - VAL_W'(1);
      end else begin
        count_d   = '0;
        expired_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= default_of(i);
      state_q   <= IDLE;
      value_q   <= default_of(0);
      count_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      param_q   <= param_d;
      state_q   <= state_d;
      value_q   <= value_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      expired_q <= expired_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.expired  = expired_q;
  assign bus.prog_ack = ack_q;
  assign bus.prog_err = err_q;

endmodule

// File: tb/tb_time_param_timer.sv
// tb/tb_time_param_timer.sv - scoreboard bench for time_param_timer against a behavioural model
module tb_time_param_timer;
  localparam int NP = 3;
  localparam int SW = 2;
  localparam int VW = 4;
  localparam logic [NP*VW-1:0] DEF = {4'd2, 4'd3, 4'd6};

  typedef struct packed {
    logic [3:0] value;
    logic [3:0] count;
    logic       busy;
    logic       expired;
    logic       ack;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_param_timer_if #(.SEL_W(SW), .VAL_W(VW)) bus ();

  time_param_timer #(.NUM_PARAMS(NP), .SEL_W(SW), .VAL_W(VW), .DEFAULTS(DEF)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  int m_par[NP];
  int m_rem;
  bit m_run;

  function automatic int def_of(int i);
    return (i == 0) ? 6 : (i == 1) ? 3 : 2;
  endfunction

  function automatic exp_t model_reset();
    exp_t e;
    for (int i = 0; i < NP; i++) m_par[i] = def_of(i);
    m_run = 0;
    m_rem = 0;
    e = '0;
    e.value = 4'(def_of(0));
    return e;
  endfunction

  function automatic exp_t model_step(bit preq, int psel, int pval, int isel, bit st, bit ab, bit tk);
    exp_t e;
    int   shown;
    bit   locked;
    e = '0;
    shown = (isel < NP) ? m_par[isel] : 15;
    e.value = 4'(shown);
`ifdef TP_PROG_LOCK_EN
    locked = m_run;
`else
    locked = 0;
`endif
    if (ab) begin
      m_run = 0;
      m_rem = 0;
    end else if (st) begin
      m_run = 1;
      m_rem = shown;
    end else if (m_run && tk) begin
      m_rem = m_rem - 1;
      if (m_rem <= 0) begin
        m_rem = 0;
        m_run = 0;
        e.expired = 1;
      end
    end
    if (preq) begin
      if (locked) e.err = 1;
      else if (psel < NP) begin
        e.ack = 1;
        m_par[psel] = (pval == 0) ? def_of(psel) : pval;
      end else begin
        e.err = 1;
        for (int i = 0; i < NP; i++) m_par[i] = def_of(i);
      end
    end
    e.count = 4'(m_rem);
    e.busy  = m_run;
    return e;
  endfunction

  task automatic set_idle();
    bus.prog_req = 0; bus.prog_sel = '0; bus.prog_value = '0;
    bus.interval_sel = '0; bus.start = 0; bus.abort = 0; bus.tick = 0;
  endtask

  task automatic drive(bit preq, int psel, int pval, int isel, bit st, bit ab, bit tk);
    exp_t e;
    bus.prog_req     = preq;
    bus.prog_sel     = SW'(psel);
    bus.prog_value   = VW'(pval);
    bus.interval_sel = SW'(isel);
    bus.start        = st;
    bus.abort        = ab;
    bus.tick         = tk;
    e = model_step(preq, psel, pval, isel, st, ab, tk);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle(int n, int isel);
    for (int i = 0; i < n; i++) drive(0, 0, 0, isel, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      got = {bus.value, bus.count, bus.busy, bus.expired, bus.prog_ack, bus.prog_err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL outputs cycle=%0d got value=%0d count=%0d busy=%0b expired=%0b ack=%0b err=%0b required value=%0d count=%0d busy=%0b expired=%0b ack=%0b err=%0b",
                 cyc, got.value, got.count, got.busy, got.expired, got.ack, got.err,
                 e.value, e.count, e.busy, e.expired, e.ack, e.err);
      end
    end
  end

  initial begin
    exp_t r;
    set_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    r = model_reset();
    sb_q.push_back(r);
    @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 4; i++) drive(0, 0, 0, i, 0, 0, 0);
    idle(1, 3);

    drive(1, 1, 9, 1, 0, 0, 0);
    idle(2, 1);
    drive(1, 1, 0, 1, 0, 0, 0);
    idle(2, 1);

    for (int i = 0; i < 3; i++) drive(1, i, 9, i, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, i, 0, 0, 0);

    drive(0, 0, 0, 2, 1, 0, 0);
    drive(0, 0, 0, 2, 0, 0, 1);
    idle(1, 2);
    drive(0, 0, 0, 2, 0, 0, 1);
    idle(2, 2);

    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 1, 1, 1);
    idle(2, 0);

    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 5, 0, 0, 0, 1);
    idle(2, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 5, 0, 0, 0, 0);
    idle(2, 0);

    drive(1, 2, 7, 2, 1, 0, 0);
    drive(0, 0, 0, 2, 1, 0, 1);
    drive(1, 3, 0, 2, 0, 0, 1);
    idle(3, 2);
    drive(0, 0, 0, 3, 1, 0, 0);
    idle(2, 3);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(9) < 2, $urandom_range(3),
            ($urandom_range(3) == 0) ? 0 : $urandom_range(15),
            $urandom_range(3), $urandom_range(9) == 0,
            $urandom_range(19) == 0, $urandom_range(9) < 4);
    end

    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1 rst_n = 0;
    set_idle();
    r = model_reset();
    #1 sb_q.push_back(r);
    @(posedge clk);
    #1 rst_n = 1;
    idle(3, 1);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
